// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider serving RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve on the accept edge.
module seq_divider #(
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] dividend,
  input  logic [BITWIDTH-1:0] divisor,
  input  logic                is_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] quotient,
  output logic [BITWIDTH-1:0] remainder
);

  localparam int CW = $clog2(BITWIDTH + 1);
  localparam logic [BITWIDTH-1:0] ALL_ONES = '1;
  localparam logic [BITWIDTH-1:0] MSB_ONLY = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BITWIDTH-1:0] dvd_q, dvd_d;    // |dividend| shifting out, quotient bits shifting in
  logic [BITWIDTH-1:0] dvs_q, dvs_d;
  logic [BITWIDTH-1:0] prem_q, prem_d;
  logic [BITWIDTH-1:0] quo_q, quo_d;
  logic [BITWIDTH-1:0] rem_q, rem_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;

  logic                dvd_neg, dvs_neg;
  logic [BITWIDTH-1:0] dvd_abs, dvs_abs;
  logic [BITWIDTH:0]   shifted;
  logic [BITWIDTH-1:0] trial, prem_step, quo_step;
  logic                ge;

  assign dvd_neg = is_signed & dividend[BITWIDTH-1];
  assign dvs_neg = is_signed & divisor[BITWIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dvs_abs = dvs_neg ? -divisor : divisor;

  // When the trial succeeds the difference is below the divisor, so W bits suffice.
  assign shifted   = {prem_q, dvd_q[BITWIDTH-1]};
  assign ge        = shifted >= {1'b0, dvs_q};
  assign trial     = shifted[BITWIDTH-1:0] - dvs_q;
  assign prem_step = ge ? trial : shifted[BITWIDTH-1:0];
  assign quo_step  = {dvd_q[BITWIDTH-2:0], ge};

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              state_d = DONE;
              quo_d   = ALL_ONES;
              rem_d   = dividend;
            end else if (is_signed && dividend == MSB_ONLY && divisor == ALL_ONES) begin
              state_d = DONE;
              quo_d   = dividend;
              rem_d   = '0;
            end else begin
              state_d = CALC;
              dvd_d   = dvd_abs;
              dvs_d   = dvs_abs;
              negq_d  = dvd_neg ^ dvs_neg;
              negr_d  = dvd_neg;
              prem_d  = '0;
              cnt_d   = CW'(BITWIDTH);
            end
          end
        end
        CALC: begin
          prem_d = prem_step;
          dvd_d  = quo_step;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            quo_d   = negq_q ? -quo_step : quo_step;
            rem_d   = negr_q ? -prem_step : prem_step;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results,
// a negedge monitor checks latency and values whenever out_valid is seen.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] quotient;
  logic [31:0] remainder;

  seq_divider #(.BITWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: values and latency checked on first sight, entry retired on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          check("quotient", quotient, sb[0].q);
          check("remainder", remainder, sb[0].r);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1; waits for in_ready, issues one request, scrambles inputs afterwards.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input int lat,
                        input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("req_ready_timeout", 32'(in_ready), 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0;
    is_signed = ~s;
    if (push) sb.push_back('{q: eq, r: er, lat: lat, acc: cyc});
  endtask

  // Waits for out_valid; optionally checks that in_ready stays low meanwhile.
  task automatic wait_result(input bit chk_busy);
    int n = 0;
    bit busy_ok = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (chk_busy) check("in_ready_low_while_busy", 32'(busy_ok), 32'd1);
    if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er, input int lat);
    do_req(a, b, s, eq, er, lat, 1'b1);
    wait_result(1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit any_valid;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned 100/7 with busy check.
    do_req(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32, 1'b1);
    wait_result(1'b1);
    @(posedge clk); #1;

    run(32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
    run(32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,        32);
    run(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 32);
    run(32'h0000_1234, 32'd0,        1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 0);
    run(32'h0000_1234, 32'd0,        1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,        0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,        32'h8000_0000, 32);
    run(32'd0,         32'd5,        1'b0, 32'd0,        32'd0,        32);

    // Back-pressure: hold DONE for five cycles, then a back-to-back request.
    out_ready = 1'b0;
    do_req(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 32, 1'b1);
    wait_result(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", quotient, 32'd100);
      check("bp_remainder", remainder, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    run(32'h1234_5678, 32'h0000_0100, 1'b0, 32'h0012_3456, 32'h0000_0078, 32);

    // Flush at iteration 10: result must never appear.
    do_req(32'd500, 32'd3, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    any_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) any_valid = 1'b1;
    end
    check("flush_no_result", 32'(any_valid), 32'd0);

    // Asynchronous reset mid-CALC.
    do_req(32'd900, 32'd9, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F, 32);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
